execute_stage: RTL

Parametrised EX stage of the pipelined MIPS core, sitting between the ID/EX and EX/MEM pipeline registers. It generalises the single-cycle execute block: configurable datapath width, full R-type funct decode including shifts, `bne` as well as `beq` resolution, and registered EX/MEM outputs. It adds an iterative multiply/divide unit with HI/LO registers and a stall interlock back to the front of the pipeline.

---
 rtl/execute_pkg.sv | 44 ++++
 rtl/muldiv_unit.sv | 128 ++++++++++++
 rtl/execute_stage.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/execute_pkg.sv
// Shared types and constants for the EX stage: funct codes, ALU controls and
// the multiply/divide FSM encodings.
package execute_pkg;

    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
    localparam logic [5:0] FUNCT_SLL   = 6'b000000;
    localparam logic [5:0] FUNCT_SRL   = 6'b000010;
    localparam logic [5:0] FUNCT_SRA   = 6'b000011;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT,
        ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_MFHI, ALU_MFLO, ALU_MD
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        MD_IDLE, MD_BUSY, MD_DONE
    } md_state_e;

    // Encoded so the low two funct bits of MULT..DIVU map straight across.
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_e;

    function automatic md_op_e funct_to_md_op(input logic [5:0] funct);
        return md_op_e'(funct[1:0]);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply (radix-2 shift-add) and restoring divide on operand
// magnitudes, XLEN busy cycles per operation, owning the HI/LO registers.
module muldiv_unit
    import execute_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  md_op_e          op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CNT_W = $clog2(XLEN);

    md_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic            is_mul_q;
    logic            neg_q, neg_r, div_zero;
    logic [XLEN-1:0] opb_q, acc_hi, acc_lo;

    logic            in_signed;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   mul_sum, div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_sub, hi_step, lo_step;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] res_hi, res_lo;

    assign busy = (state == MD_BUSY);
    assign done = (state == MD_DONE);

    assign in_signed = (op == OP_MULT) || (op == OP_DIV);
    assign mag_a     = (in_signed && a[XLEN-1]) ? -a : a;
    assign mag_b     = (in_signed && b[XLEN-1]) ? -b : b;

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (start && !abort) state_nxt = MD_BUSY;
            MD_BUSY: begin
                if (abort)              state_nxt = MD_IDLE;
                else if (cnt == '0)     state_nxt = MD_DONE;
            end
            MD_DONE: state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    // One iteration of either algorithm; the final step feeds HI/LO directly.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        div_sub   = div_shift[XLEN-1:0] - opb_q;
        if (is_mul_q) begin
            hi_step = mul_sum[XLEN:1];
            lo_step = {mul_sum[0], acc_lo[XLEN-1:1]};
        end else if (div_ge) begin
            hi_step = div_sub;
            lo_step = {acc_lo[XLEN-2:0], 1'b1};
        end else begin
            hi_step = div_shift[XLEN-1:0];
            lo_step = {acc_lo[XLEN-2:0], 1'b0};
        end
        prod = {hi_step, lo_step};
        if (is_mul_q) begin
            prod   = neg_q ? -prod : prod;
            res_hi = prod[2*XLEN-1:XLEN];
            res_lo = prod[XLEN-1:0];
        end else begin
            res_hi = neg_r ? -hi_step : hi_step;
            res_lo = div_zero ? '1 : (neg_q ? -lo_step : lo_step);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= MD_IDLE;
            cnt      <= '0;
            is_mul_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            opb_q    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                MD_IDLE: begin
                    if (start && !abort) begin
                        is_mul_q <= (op == OP_MULT) || (op == OP_MULTU);
                        neg_q    <= in_signed && (a[XLEN-1] ^ b[XLEN-1]);
                        neg_r    <= in_signed && a[XLEN-1];
                        div_zero <= (b == '0);
                        opb_q    <= mag_b;
                        acc_hi   <= '0;
                        acc_lo   <= mag_a;
                        cnt      <= CNT_W'(XLEN - 1);
                    end
                end
                MD_BUSY: begin
                    if (!abort) begin
                        acc_hi <= hi_step;
                        acc_lo <= lo_step;
                        cnt    <= cnt - 1'b1;
                        if (cnt == '0) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Pipelined MIPS EX stage: ALU with funct decode, branch resolution,
// registered EX/MEM outputs and the mul/div stall interlock.
module execute_stage
    import execute_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [1:0]         ctrl_aluOp,
    input  logic               ctrl_aluSrc,
    input  logic               ctrl_regDest,
    input  logic               ctrl_regWrite,
    input  logic               ctrl_branch,
    input  logic               ctrl_branchNe,
    input  logic [XLEN-1:0]    read_data_1,
    input  logic [XLEN-1:0]    read_data_2,
    input  logic [XLEN-1:0]    ext_imm,
    input  logic [XLEN-1:0]    next_pc,
    input  logic [RADDR_W-1:0] instr_20_16,
    input  logic [RADDR_W-1:0] instr_15_11,
    output logic               stall,
    output logic               ex_valid,
    output logic [XLEN-1:0]    alu_result,
    output logic [RADDR_W-1:0] write_register,
    output logic               reg_write,
    output logic [XLEN-1:0]    branch_target,
    output logic               branch_taken,
    output logic [XLEN-1:0]    hi,
    output logic [XLEN-1:0]    lo
);

    logic [5:0]      funct;
    logic [4:0]      shamt;
    logic [XLEN-1:0] op_a, op_b, result;
    alu_ctrl_e       alu_ctrl;
    logic            funct_ok, is_md, is_mf, md_start, md_busy, md_done;
    logic            wr_en, taken;
    logic [XLEN-1:0] target;

    assign funct = ext_imm[5:0];
    assign shamt = ext_imm[10:6];
    assign op_a  = read_data_1;
    assign op_b  = ctrl_aluSrc ? ext_imm : read_data_2;

    always_comb begin
        alu_ctrl = ALU_ADD;
        funct_ok = 1'b1;
        case (ctrl_aluOp)
            2'b00: alu_ctrl = ALU_ADD;
            2'b01: alu_ctrl = ALU_SUB;
            2'b11: alu_ctrl = ALU_OR;
            default: begin
                case (funct)
                    FUNCT_ADD:   alu_ctrl = ALU_ADD;
                    FUNCT_SUB:   alu_ctrl = ALU_SUB;
                    FUNCT_AND:   alu_ctrl = ALU_AND;
                    FUNCT_OR:    alu_ctrl = ALU_OR;
                    FUNCT_XOR:   alu_ctrl = ALU_XOR;
                    FUNCT_NOR:   alu_ctrl = ALU_NOR;
                    FUNCT_SLT:   alu_ctrl = ALU_SLT;
                    FUNCT_SLTU:  alu_ctrl = ALU_SLTU;
                    FUNCT_SLL:   alu_ctrl = ALU_SLL;
                    FUNCT_SRL:   alu_ctrl = ALU_SRL;
                    FUNCT_SRA:   alu_ctrl = ALU_SRA;
                    FUNCT_MFHI:  alu_ctrl = ALU_MFHI;
                    FUNCT_MFLO:  alu_ctrl = ALU_MFLO;
                    FUNCT_MULT, FUNCT_MULTU,
                    FUNCT_DIV, FUNCT_DIVU: alu_ctrl = ALU_MD;
                    default:     funct_ok = 1'b0;
                endcase
            end
        endcase
    end

    assign is_md = (ctrl_aluOp == 2'b10) && funct_ok && (alu_ctrl == ALU_MD);
    assign is_mf = (ctrl_aluOp == 2'b10) && funct_ok &&
                   ((alu_ctrl == ALU_MFHI) || (alu_ctrl == ALU_MFLO));

    // A mul/div holds until its DONE cycle; HI/LO readers wait for IDLE.
    assign stall    = !reset && in_valid &&
                      ((is_md && !md_done) || (is_mf && (md_busy || md_done)));
    assign md_start = in_valid && is_md && !flush && !md_busy && !md_done;

    always_comb begin
        result = '0;
        if (funct_ok) begin
            case (alu_ctrl)
                ALU_ADD:  result = op_a + op_b;
                ALU_SUB:  result = op_a - op_b;
                ALU_AND:  result = op_a & op_b;
                ALU_OR:   result = op_a | op_b;
                ALU_XOR:  result = op_a ^ op_b;
                ALU_NOR:  result = ~(op_a | op_b);
                ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                ALU_SLTU: result = {{(XLEN-1){1'b0}}, op_a < op_b};
                ALU_SLL:  result = op_b << shamt;
                ALU_SRL:  result = op_b >> shamt;
                ALU_SRA:  result = $signed(op_b) >>> shamt;
                ALU_MFHI: result = hi;
                ALU_MFLO: result = lo;
                default:  result = '0;
            endcase
        end
    end

    assign wr_en  = ctrl_regWrite && !((ctrl_aluOp == 2'b10) && (!funct_ok || is_md));
    assign taken  = ctrl_branch && ((op_a == op_b) ^ ctrl_branchNe);
    assign target = next_pc + (ext_imm << 2);

    muldiv_unit #(.XLEN(XLEN)) u_muldiv (
        .clk   (clk),
        .reset (reset),
        .start (md_start),
        .abort (flush),
        .op    (funct_to_md_op(funct)),
        .a     (op_a),
        .b     (op_b),
        .busy  (md_busy),
        .done  (md_done),
        .hi    (hi),
        .lo    (lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid       <= 1'b0;
            alu_result     <= '0;
            write_register <= '0;
            reg_write      <= 1'b0;
            branch_target  <= '0;
            branch_taken   <= 1'b0;
        end else if (flush || !in_valid || stall) begin
            ex_valid <= 1'b0;
        end else begin
            ex_valid       <= 1'b1;
            alu_result     <= result;
            write_register <= ctrl_regDest ? instr_15_11 : instr_20_16;
            reg_write      <= wr_en;
            branch_target  <= target;
            branch_taken   <= taken;
        end
    end

endmodule
